// File: rtl/traffic_pkg.sv
// Shared state encoding, light codes and phase helpers for the traffic-light controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    RED_TO_MAIN,  // all red, waiting to hand over to main road
    MAIN_G,       // main green, side red
    MAIN_Y,       // main yellow, side red
    RED_TO_SIDE,  // all red, waiting to hand over to side road
    SIDE_G,       // side green, main red
    SIDE_Y,       // side yellow, main red
    FAULT         // counter stopped answering, both roads blink yellow
  } state_t;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

  // Green phases run on the long interval, everything else on the short one.
  function automatic logic expects_long(input state_t s);
    return (s == MAIN_G) || (s == SIDE_G);
  endfunction

  function automatic state_t next_phase(input state_t s);
    state_t n;
    case (s)
      RED_TO_MAIN: n = MAIN_G;
      MAIN_G:      n = MAIN_Y;
      MAIN_Y:      n = RED_TO_SIDE;
      RED_TO_SIDE: n = SIDE_G;
      SIDE_G:      n = SIDE_Y;
      SIDE_Y:      n = RED_TO_MAIN;
      default:     n = FAULT;
    endcase
    return n;
  endfunction

  // Returns {main_light, side_light}.
  function automatic logic [5:0] phase_lights(input state_t s);
    logic [5:0] l;
    case (s)
      MAIN_G:  l = {LT_GRN, LT_RED};
      MAIN_Y:  l = {LT_YEL, LT_RED};
      SIDE_G:  l = {LT_RED, LT_GRN};
      SIDE_Y:  l = {LT_RED, LT_YEL};
      FAULT:   l = {LT_YEL, LT_YEL};
      default: l = {LT_RED, LT_RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// Watchdog counter: flags a missing done after WDOG_MAX cycles, and doubles as
// the blink divider once the controller has faulted.
module ctrl_watchdog #(
  parameter int WDOG_W    = 8,
  parameter int WDOG_MAX  = 200,
  parameter int BLINK_CYC = 25
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_blink_mode,
  output logic o_expire,
  output logic o_blink_tick
);

  localparam logic [WDOG_W-1:0] MAX_M1   = WDOG_W'(WDOG_MAX - 1);
  localparam logic [WDOG_W-1:0] BLINK_M1 = WDOG_W'(BLINK_CYC - 1);

  logic [WDOG_W-1:0] r_cnt;
  logic              w_blink_tick;

  assign w_blink_tick = i_blink_mode && (r_cnt == BLINK_M1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (i_clear || w_blink_tick)
      r_cnt <= '0;
    else if (i_enable)
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire     = i_enable && !i_blink_mode && (r_cnt == MAX_M1);
  assign o_blink_tick = w_blink_tick;

endmodule

// File: rtl/traffic_ctrl.sv
// Two-road traffic-light sequencer driving an external interval counter via
// trL/trS start pulses and advancing on its tL/tS done pulses.
module traffic_ctrl #(
  parameter int WDOG_W    = 8,
  parameter int WDOG_MAX  = 200,
  parameter int BLINK_CYC = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car,
  input  logic       tL,
  input  logic       tS,
  output logic       trL,
  output logic       trS,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       fault
);
  import traffic_pkg::*;

  state_t     r_state, w_state_nxt;
  logic       r_start_pend, r_car_req;
  logic       r_trl, r_trs, r_fault;
  logic [2:0] r_main, r_side, w_main_nxt, w_side_nxt;
  logic       w_issue, w_trig_long, w_accept, w_expire, w_blink_tick;
  logic       w_enter_fault, w_enter_side;

  // A done arriving while our own trigger is still on the wire is a leftover.
  assign w_accept = (expects_long(r_state) ? tL : tS) && !(r_trl || r_trs);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_main_nxt  = r_main;
    w_side_nxt  = r_side;
    if (r_start_pend) begin
      w_issue = 1'b1;
    end else if (r_state != FAULT) begin
      if (w_accept) begin
        w_issue = 1'b1;
        if (!(r_state == MAIN_G && !r_car_req))
          w_state_nxt = next_phase(r_state);
      end else if (w_expire) begin
        w_state_nxt = FAULT;
      end
    end
    if (w_state_nxt == FAULT) begin
      if (r_state != FAULT) begin
        w_main_nxt = LT_YEL;
        w_side_nxt = LT_YEL;
      end else if (w_blink_tick) begin
        w_main_nxt = r_main ^ LT_YEL;
        w_side_nxt = r_side ^ LT_YEL;
      end
    end else begin
      {w_main_nxt, w_side_nxt} = phase_lights(w_state_nxt);
    end
  end

  assign w_trig_long   = expects_long(w_state_nxt);
  assign w_enter_fault = (w_state_nxt == FAULT) && (r_state != FAULT);
  assign w_enter_side  = (w_state_nxt == SIDE_G) && (r_state != SIDE_G);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RED_TO_MAIN;
      r_start_pend <= 1'b1;
      r_car_req    <= 1'b0;
      r_trl        <= 1'b0;
      r_trs        <= 1'b0;
      r_main       <= LT_RED;
      r_side       <= LT_RED;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_start_pend <= 1'b0;
      r_trl        <= w_issue && w_trig_long;
      r_trs        <= w_issue && !w_trig_long;
      r_main       <= w_main_nxt;
      r_side       <= w_side_nxt;
      r_fault      <= (w_state_nxt == FAULT);
      if (w_enter_side)
        r_car_req <= 1'b0;
      else if (car && r_state != FAULT)
        r_car_req <= 1'b1;
    end
  end

  ctrl_watchdog #(
    .WDOG_W   (WDOG_W),
    .WDOG_MAX (WDOG_MAX),
    .BLINK_CYC(BLINK_CYC)
  ) u_wdog (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_clear     (w_issue || w_enter_fault),
    .i_enable    (!r_start_pend),
    .i_blink_mode(r_state == FAULT),
    .o_expire    (w_expire),
    .o_blink_tick(w_blink_tick)
  );

  assign trL        = r_trl;
  assign trS        = r_trs;
  assign main_light = r_main;
  assign side_light = r_side;
  assign fault      = r_fault;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Randomized and directed checks of traffic_ctrl against a phase-table reference model.
module tb_traffic_ctrl;
  localparam int WDOG_MAX  = 64;
  localparam int BLINK_CYC = 25;

  logic       clk = 1'b0, reset = 1'b0, car = 1'b0, tL = 1'b0, tS = 1'b0;
  logic       trL, trS, fault;
  logic [2:0] main_light, side_light;

  traffic_ctrl #(.WDOG_W(8), .WDOG_MAX(WDOG_MAX), .BLINK_CYC(BLINK_CYC)) dut (
    .clk(clk), .reset(reset), .car(car), .tL(tL), .tS(tS),
    .trL(trL), .trS(trS), .main_light(main_light), .side_light(side_light),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // Phase order: red->main, main G, main Y, red->side, side G, side Y.
  localparam logic [2:0] MAIN_TAB [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
  localparam logic [2:0] SIDE_TAB [6] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
  localparam bit         LONG_TAB [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  int n_tests = 0, n_fail = 0;
  int m_phase, m_waited, m_blink_cnt;
  bit m_pend, m_fresh, m_car_req, m_fault, m_blink_on, m_trl, m_trs;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_waited = 0; m_blink_cnt = 0;
    m_pend = 1; m_fresh = 0; m_car_req = 0; m_fault = 0; m_blink_on = 0;
    m_trl = 0; m_trs = 0;
  endtask

  task automatic model_step(input bit c, input bit l, input bit s);
    bit issue, was_fault, done, enter_side;
    issue = 0; enter_side = 0; was_fault = m_fault;
    if (m_fault) begin
      m_blink_cnt++;
      if (m_blink_cnt == BLINK_CYC) begin
        m_blink_cnt = 0;
        m_blink_on  = !m_blink_on;
      end
    end else if (m_pend) begin
      m_pend = 0;
      issue  = 1;
    end else begin
      done = LONG_TAB[m_phase] ? l : s;
      if (done && !m_fresh) begin
        issue = 1;
        if (!(m_phase == 1 && !m_car_req)) begin
          m_phase    = (m_phase + 1) % 6;
          enter_side = (m_phase == 4);
        end
      end else if (m_waited == WDOG_MAX - 1) begin
        m_fault = 1; m_blink_cnt = 0; m_blink_on = 1;
      end else begin
        m_waited++;
      end
    end
    if (enter_side) m_car_req = 0;
    else if (c && !was_fault) m_car_req = 1;
    if (issue) m_waited = 0;
    m_fresh = issue;
    m_trl   = issue && LONG_TAB[m_phase];
    m_trs   = issue && !LONG_TAB[m_phase];
  endtask

  function automatic logic [2:0] exp_main();
    return m_fault ? (m_blink_on ? 3'b010 : 3'b000) : MAIN_TAB[m_phase];
  endfunction

  function automatic logic [2:0] exp_side();
    return m_fault ? (m_blink_on ? 3'b010 : 3'b000) : SIDE_TAB[m_phase];
  endfunction

  task automatic check_all();
    check_eq("main_light", 8'(main_light), 8'(exp_main()));
    check_eq("side_light", 8'(side_light), 8'(exp_side()));
    check_eq("trL", 8'(trL), 8'(m_trl));
    check_eq("trS", 8'(trS), 8'(m_trs));
    check_eq("fault", 8'(fault), 8'(m_fault));
  endtask

  // Entered at a negedge, leaves at the next negedge after checking.
  task automatic step(input bit c, input bit l, input bit s);
    car = c; tL = l; tS = s;
    @(posedge clk);
    model_step(c, l, s);
    @(negedge clk);
    check_all();
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 100 && !(m_phase == target && m_fresh && !m_fault); i++) begin
      bit lng;
      lng = LONG_TAB[m_phase];
      step(1'b1, lng, !lng);
    end
    check_eq("run_to_phase", 8'(m_phase), 8'(target));
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    check_eq({tag, "_main"}, 8'(main_light), 8'h4);
    check_eq({tag, "_side"}, 8'(side_light), 8'h4);
    check_eq({tag, "_trL"}, 8'(trL), 8'h0);
    check_eq({tag, "_trS"}, 8'(trS), 8'h0);
    check_eq({tag, "_fault"}, 8'(fault), 8'h0);
    model_reset();
    car = 1'b0; tL = 1'b0; tS = 1'b0;
    @(negedge clk);
    check_all();
    reset = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b1;

    step(0, 0, 0);
    check_eq("first_trS", 8'(trS), 8'h1);
    repeat (4) step(0, 0, 0);
    step(0, 0, 1);
    check_eq("enter_main_g", 8'(main_light), 8'h1);

    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);

    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 0, 0);
    step(1, 0, 1);
    check_eq("side_green", 8'(side_light), 8'h1);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 1, 0);
    check_eq("car_req_cleared", 8'(main_light), 8'h1);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

    run_to(4);
    step(0, 0, 0);
    async_reset("rst_side_g");
    step(0, 0, 0);
    step(0, 0, 1);

    run_to(1);
    for (int i = 0; i < WDOG_MAX; i++) step(0, 0, 0);
    check_eq("wdog_fault", 8'(fault), 8'h1);
    for (int i = 0; i < 3 * BLINK_CYC + 5; i++) step(i[0], 0, 0);
    repeat (3) step(1, 1, 1);
    async_reset("rst_fault");
    step(0, 0, 0);
    step(0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
